// File: rtl/bcd_display_scan_if.sv
// Display-scan bus: scan controls and BCD value in, active-low segment and anode lines out.
interface bcd_display_scan_if #(
   parameter int unsigned NUM_DIGITS = 3
);
   logic                    i_ena;
   logic                    i_wr;
   logic [4*NUM_DIGITS-1:0] i_bcd;
   logic                    i_lzb;
   logic [NUM_DIGITS-1:0]   i_blink_mask;
   logic                    i_blink_phase;
   logic [NUM_DIGITS-1:0]   i_dp;
   logic [7:0]              o_seg;
   logic [NUM_DIGITS-1:0]   o_an;

   modport master (
      output i_ena, i_wr, i_bcd, i_lzb, i_blink_mask, i_blink_phase, i_dp,
      input  o_seg, o_an
   );

   modport slave (
      input  i_ena, i_wr, i_bcd, i_lzb, i_blink_mask, i_blink_phase, i_dp,
      output o_seg, o_an
   );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment scanner for the BCD counter chain.
// Snapshots the value once per frame (or on i_wr) so the display never tears,
// with leading-zero blanking, per-digit blink and decimal points.
module bcd_display_scan #(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned DWELL      = 4,
   parameter int unsigned BLANK      = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   bcd_display_scan_if.slave    bus
);
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned TICK_W = 8;
   localparam int unsigned BCD_W  = 4 * NUM_DIGITS;

   localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK - 1);
   localparam logic [TICK_W-1:0] SHOW_LAST  = TICK_W'(DWELL - BLANK - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {S_BLANK = 1'b0, S_SHOW = 1'b1} state_t;

   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [TICK_W-1:0]     tick;
   logic [BCD_W-1:0]      shadow;
   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q;

   logic [NUM_DIGITS-1:0] lz_c;
   logic                  all_zero_c;
   logic [3:0]            digit_c;
   logic                  blank_c;
   logic [7:0]            seg_c;
   logic [NUM_DIGITS-1:0] an_c;

   // Nibble to active-low {g,f,e,d,c,b,a}; non-BCD values show a dash.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   // Leading-zero map: walk down from the MSD while every digit seen is zero; digit 0 is never blanked.
   always_comb begin
      lz_c       = '0;
      all_zero_c = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         all_zero_c = all_zero_c & (shadow[4*k +: 4] == 4'd0);
         if (k != 0) lz_c[k] = all_zero_c;
      end
   end

   // Segment/anode pattern for the digit about to be shown; blink wins over lzb, dp always passes.
   always_comb begin
      digit_c = shadow[4*int'(idx) +: 4];
      blank_c = (bus.i_blink_mask[idx] & bus.i_blink_phase) | (bus.i_lzb & lz_c[idx]);
      seg_c   = {~bus.i_dp[idx], blank_c ? 7'h7F : decode(digit_c)};
      an_c    = ~(NUM_DIGITS'(1) << idx);
   end

   // Scan FSM with registered outputs; shadow reloads on i_wr or on frame wrap.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state  <= S_BLANK;
         idx    <= '0;
         tick   <= '0;
         shadow <= '0;
         seg_q  <= 8'hFF;
         an_q   <= '1;
      end else begin
         if (bus.i_wr) shadow <= bus.i_bcd;
         if (bus.i_ena) begin
            case (state)
               S_BLANK: begin
                  if (tick == BLANK_LAST) begin
                     state <= S_SHOW;
                     tick  <= '0;
                     seg_q <= seg_c;
                     an_q  <= an_c;
                  end else begin
                     tick <= tick + TICK_W'(1);
                  end
               end
               S_SHOW: begin
                  if (tick == SHOW_LAST) begin
                     state <= S_BLANK;
                     tick  <= '0;
                     seg_q <= 8'hFF;
                     an_q  <= '1;
                     if (idx == IDX_LAST) begin
                        idx    <= '0;
                        shadow <= bus.i_bcd;
                     end else begin
                        idx <= idx + IDX_W'(1);
                     end
                  end else begin
                     tick <= tick + TICK_W'(1);
                  end
               end
               default: begin
                  state <= S_BLANK;
                  tick  <= '0;
               end
            endcase
         end
      end
   end

   assign bus.o_seg = seg_q;
   assign bus.o_an  = an_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: the driver queues the expected
// {anode, segment} pattern of each digit slot, the monitor checks every slot entry.
module tb_bcd_display_scan;
   logic clk;
   logic rst_n;

   bcd_display_scan_if #(.NUM_DIGITS(3)) bus ();

   bcd_display_scan #(.NUM_DIGITS(3), .DWELL(4), .BLANK(1)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned slot_no = 0;
   logic [10:0] exp_q[$];
   logic [2:0]  prev_an = 3'bxxx;
   logic [10:0] held;

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                  name, act[10:8], act[7:0], exp[10:8], exp[7:0]);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected segment bytes for digit slots 0, 1, 2 of one frame.
   task automatic push3(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
      exp_q.push_back({3'b110, s0});
      exp_q.push_back({3'b101, s1});
      exp_q.push_back({3'b011, s2});
   endtask

   // Monitor: a slot starts when anodes go from all-off to one digit enabled.
   always @(negedge clk) begin
      logic [10:0] e;
      if (prev_an === 3'b111 && bus.o_an !== 3'b111) begin
         slot_no++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slot_unexpected #%0d: got an=%b seg=%h, expected no slot",
                     slot_no, bus.o_an, bus.o_seg);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("slot#%0d", slot_no), {bus.o_an, bus.o_seg}, e);
         end
      end
      prev_an = bus.o_an;
   end

   initial begin
      rst_n              = 1'b0;
      bus.i_ena          = 1'b1;
      bus.i_wr           = 1'b0;
      bus.i_bcd          = 12'h000;
      bus.i_lzb          = 1'b0;
      bus.i_blink_mask   = 3'b000;
      bus.i_blink_phase  = 1'b0;
      bus.i_dp           = 3'b000;
      tick(2);
      check("reset_state", {bus.o_an, bus.o_seg}, {3'b111, 8'hFF});

      // Reset mid-scan: digit1 is being shown when reset lands.
      rst_n = 1'b1;
      exp_q.push_back({3'b110, 8'hC0});
      exp_q.push_back({3'b101, 8'hC0});
      tick(6);
      rst_n = 1'b0;
      #1;
      check("reset_waits_for_edge", {bus.o_an, bus.o_seg}, {3'b101, 8'hC0});
      @(negedge clk);
      check("reset_mid_scan", {bus.o_an, bus.o_seg}, {3'b111, 8'hFF});

      // F0: i_wr loads 059 on the first edge; digit0 already latched old shadow 0.
      rst_n     = 1'b1;
      bus.i_bcd = 12'h059;
      bus.i_wr  = 1'b1;
      push3(8'hC0, 8'h92, 8'hC0);
      tick(1);
      bus.i_wr = 1'b0;
      tick(1);
      check("dark_after_digit0", {bus.o_an, bus.o_seg}, {3'b110, 8'hC0});
      tick(10);

      // F1: full 059; bcd moves to 100 during digit1 slot without tearing.
      push3(8'h90, 8'h92, 8'hC0);
      tick(5);
      bus.i_bcd = 12'h100;
      tick(7);

      // F2: 100 appears after the wrap.
      push3(8'hC0, 8'hC0, 8'hF9);
      bus.i_bcd = 12'h007;
      tick(12);

      // F3..F5: leading-zero blanking.
      bus.i_lzb = 1'b1;
      push3(8'hF8, 8'hFF, 8'hFF);
      bus.i_bcd = 12'h000;
      tick(12);
      push3(8'hC0, 8'hFF, 8'hFF);
      bus.i_bcd = 12'h0A0;
      tick(12);
      push3(8'hC0, 8'hBF, 8'hFF);
      bus.i_bcd = 12'h123;
      tick(12);

      // F6/F7: blink with dp on digit1.
      bus.i_lzb         = 1'b0;
      bus.i_blink_mask  = 3'b011;
      bus.i_blink_phase = 1'b1;
      bus.i_dp          = 3'b010;
      push3(8'hFF, 8'h7F, 8'hF9);
      tick(12);
      bus.i_blink_phase = 1'b0;
      push3(8'hB0, 8'h24, 8'hF9);
      tick(12);

      // F8: 50-clock enable gap mid-slot, then i_wr coinciding with the wrap.
      bus.i_blink_mask = 3'b000;
      bus.i_dp         = 3'b000;
      push3(8'hB0, 8'hA4, 8'hF9);
      tick(2);
      bus.i_ena = 1'b0;
      held = {bus.o_an, bus.o_seg};
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("ena_gap_hold", {bus.o_an, bus.o_seg}, {3'b110, 8'hB0});
      end
      check("ena_gap_unchanged", {bus.o_an, bus.o_seg}, held);
      bus.i_ena = 1'b1;
      tick(9);
      bus.i_bcd = 12'h456;
      bus.i_wr  = 1'b1;
      tick(1);
      bus.i_wr  = 1'b0;
      bus.i_bcd = 12'h789;

      // F9: value captured at the wrap edge; F10: next frame snapshot.
      push3(8'h82, 8'h92, 8'h99);
      tick(12);
      push3(8'h90, 8'h80, 8'hF8);
      tick(11);
      bus.i_ena = 1'b0;
      tick(3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL slots_missing: got %0d slots still queued, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
